// File: rtl/pulse_transmitter_pkg.sv
// Shared definitions for the pulse transmitter: symbol word layout, duration floor
// and the sequencer state encoding.
package pulse_transmitter_pkg;

    // Symbol word is {level, prescaler_sel, duration}; level/psel indices are offsets above
    // the duration field, i.e. bit TIMER_WIDTH + SYM_*_BIT of the word.
    localparam int unsigned SYM_DUR_LSB   = 0;
    localparam int unsigned SYM_PSEL_BIT  = 0;
    localparam int unsigned SYM_LEVEL_BIT = 1;

    localparam int unsigned MIN_DURATION = 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ARM,
        RUN,
        DRAIN
    } seq_state_e;

endpackage

// File: rtl/pulse_transmitter_symbol_prefetch.sv
// Symbol read sequencing: address and loop counters plus a one-entry buffer holding
// the next symbol and whether it is the final one of the program.
module pulse_transmitter_symbol_prefetch
    import pulse_transmitter_pkg::*;
#(
    parameter int unsigned TIMER_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned LOOP_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   sys_rst_n,
    input  logic                   restart,
    input  logic                   advance,
    input  logic [ADDR_WIDTH-1:0]  cfg_end_addr,
    input  logic [LOOP_WIDTH-1:0]  cfg_loop_count,
    input  logic                   cfg_loop_forever,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [TIMER_WIDTH+1:0] mem_data,
    output logic                   rdata_last,
    output logic [TIMER_WIDTH+1:0] buf_data,
    output logic                   buf_last
);

    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LOOP_WIDTH-1:0]  loop_q, loop_d;
    logic                   fetch_done_q, fetch_done_d;
    logic                   pend_q, pend_last_q, pend_last_d;
    logic [TIMER_WIDTH+1:0] buf_q, buf_d;
    logic                   buf_last_q, buf_last_d;

    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [LOOP_WIDTH-1:0]  loop_cur;
    logic                   wrap;
    logic                   final_rd;

    always_comb begin
        rd_addr   = restart ? '0 : addr_q;
        loop_cur  = restart ? cfg_loop_count : loop_q;
        // Once the final symbol has been read, further advance requests are ignored.
        mem_rd_en = restart | (advance & ~fetch_done_q);
        wrap      = (rd_addr == cfg_end_addr);
        final_rd  = wrap & ~cfg_loop_forever & (loop_cur == '0);

        addr_d       = addr_q;
        loop_d       = loop_q;
        fetch_done_d = fetch_done_q;
        pend_last_d  = 1'b0;
        if (mem_rd_en) begin
            addr_d       = wrap ? '0 : rd_addr + ADDR_WIDTH'(1);
            loop_d       = (wrap && !cfg_loop_forever && loop_cur != '0)
                           ? loop_cur - LOOP_WIDTH'(1) : loop_cur;
            fetch_done_d = final_rd;
            pend_last_d  = final_rd;
        end

        buf_d      = buf_q;
        buf_last_d = buf_last_q;
        if (pend_q) begin
            buf_d      = mem_data;
            buf_last_d = pend_last_q;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr_q       <= '0;
            loop_q       <= '0;
            fetch_done_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            buf_q        <= '0;
            buf_last_q   <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            loop_q       <= loop_d;
            fetch_done_q <= fetch_done_d;
            pend_q       <= mem_rd_en;
            pend_last_q  <= pend_last_d;
            buf_q        <= buf_d;
            buf_last_q   <= buf_last_d;
        end
    end

    assign mem_addr   = rd_addr;
    assign rdata_last = pend_last_q;
    assign buf_data   = buf_q;
    assign buf_last   = buf_last_q;

endmodule

// File: rtl/pulse_transmitter_symbol_sequencer.sv
// Plays a symbol program onto tx_out by stepping the external countdown timer one
// symbol per reload pulse, with looping, inversion and an idle level.
module pulse_transmitter_symbol_sequencer
    import pulse_transmitter_pkg::*;
#(
    parameter int unsigned PRESCALER_WIDTH = 16,
    parameter int unsigned TIMER_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH      = 5,
    parameter int unsigned LOOP_WIDTH      = 8,
    localparam int unsigned PSC_W          = $clog2(PRESCALER_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   sys_rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [ADDR_WIDTH-1:0]  cfg_end_addr,
    input  logic [LOOP_WIDTH-1:0]  cfg_loop_count,
    input  logic                   cfg_loop_forever,
    input  logic                   cfg_invert,
    input  logic                   cfg_idle_level,
    input  logic [PSC_W-1:0]       cfg_prescaler_a,
    input  logic [PSC_W-1:0]       cfg_prescaler_b,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [TIMER_WIDTH+1:0] mem_data,
    output logic                   timer_en,
    output logic [PSC_W-1:0]       timer_prescaler,
    output logic [TIMER_WIDTH-1:0] timer_duration,
    input  logic                   timer_pulse,
    output logic                   tx_out,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned LevelIdx = TIMER_WIDTH + SYM_LEVEL_BIT;
    localparam int unsigned PselIdx  = TIMER_WIDTH + SYM_PSEL_BIT;

    seq_state_e state_q, state_d;

    logic [PSC_W-1:0]       psc_q, psc_d;
    logic [TIMER_WIDTH-1:0] dur_q, dur_d;
    logic                   level_q, level_d;
    logic                   last_q, last_d;
    logic                   timer_en_q, timer_en_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   restart;
    logic                   advance;
    logic                   rdata_last;
    logic [TIMER_WIDTH+1:0] buf_data;
    logic                   buf_last;
    logic                   load_fields;
    logic [TIMER_WIDTH+1:0] sym;
    logic                   sym_last;
    logic [TIMER_WIDTH-1:0] sym_dur;

    pulse_transmitter_symbol_prefetch #(
        .TIMER_WIDTH (TIMER_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .LOOP_WIDTH  (LOOP_WIDTH)
    ) u_prefetch (
        .clk              (clk),
        .sys_rst_n        (sys_rst_n),
        .restart          (restart),
        .advance          (advance),
        .cfg_end_addr     (cfg_end_addr),
        .cfg_loop_count   (cfg_loop_count),
        .cfg_loop_forever (cfg_loop_forever),
        .mem_rd_en        (mem_rd_en),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .rdata_last       (rdata_last),
        .buf_data         (buf_data),
        .buf_last         (buf_last)
    );

    always_comb begin
        state_d     = state_q;
        timer_en_d  = timer_en_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        restart     = 1'b0;
        advance     = 1'b0;
        load_fields = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = cfg_idle_level;
                if (start && !stop) begin
                    restart = 1'b1;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                load_fields = 1'b1;
                advance     = 1'b1;
                state_d     = ARM;
            end
            ARM: begin
                timer_en_d = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (timer_pulse) begin
                    tx_d = level_q ^ cfg_invert;
                    if (last_q) begin
                        state_d = DRAIN;
                    end else begin
                        load_fields = 1'b1;
                        advance     = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (timer_pulse) begin
                    timer_en_d = 1'b0;
                    tx_d       = cfg_idle_level;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a coincident timer pulse.
        if (stop && state_q != IDLE) begin
            timer_en_d  = 1'b0;
            tx_d        = cfg_idle_level;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            advance     = 1'b0;
            load_fields = 1'b0;
            state_d     = IDLE;
        end
    end

    // Symbol 0 comes straight from memory; later symbols come from the prefetch buffer.
    always_comb begin
        sym      = (state_q == FETCH) ? mem_data : buf_data;
        sym_last = (state_q == FETCH) ? rdata_last : buf_last;
        sym_dur  = sym[SYM_DUR_LSB +: TIMER_WIDTH];

        psc_d   = psc_q;
        dur_d   = dur_q;
        level_d = level_q;
        last_d  = last_q;
        if (load_fields) begin
            psc_d   = sym[PselIdx] ? cfg_prescaler_b : cfg_prescaler_a;
            // Short durations are floored so the fields settle before the next reload.
            dur_d   = (sym_dur < TIMER_WIDTH'(MIN_DURATION)) ? TIMER_WIDTH'(MIN_DURATION)
                                                              : sym_dur;
            level_d = sym[LevelIdx];
            last_d  = sym_last;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            psc_q      <= '0;
            dur_q      <= '0;
            level_q    <= 1'b0;
            last_q     <= 1'b0;
            timer_en_q <= 1'b0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            psc_q      <= psc_d;
            dur_q      <= dur_d;
            level_q    <= level_d;
            last_q     <= last_d;
            timer_en_q <= timer_en_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign timer_en        = timer_en_q;
    assign timer_prescaler = psc_q;
    assign timer_duration  = dur_q;
    assign tx_out          = tx_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_pulse_transmitter_symbol_sequencer.sv
// Scoreboard bench for the symbol sequencer with a behavioural symbol RAM and countdown timer.
module tb_pulse_transmitter_symbol_sequencer;

    localparam int unsigned TW    = 8;
    localparam int unsigned AW    = 5;
    localparam int unsigned LW    = 8;
    localparam int unsigned PSC_W = 5;

    logic          clk = 1'b0;
    logic          sys_rst_n;
    logic          start, stop;
    logic [AW-1:0] cfg_end_addr;
    logic [LW-1:0] cfg_loop_count;
    logic          cfg_loop_forever, cfg_invert, cfg_idle_level;
    logic [PSC_W-1:0] cfg_prescaler_a, cfg_prescaler_b;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [TW+1:0] mem_data = '0;
    logic          timer_en;
    logic [PSC_W-1:0] timer_prescaler;
    logic [TW-1:0] timer_duration;
    logic          timer_pulse;
    logic          tx_out, busy, done;

    always #5 clk = ~clk;

    pulse_transmitter_symbol_sequencer dut (
        .clk              (clk),
        .sys_rst_n        (sys_rst_n),
        .start            (start),
        .stop             (stop),
        .cfg_end_addr     (cfg_end_addr),
        .cfg_loop_count   (cfg_loop_count),
        .cfg_loop_forever (cfg_loop_forever),
        .cfg_invert       (cfg_invert),
        .cfg_idle_level   (cfg_idle_level),
        .cfg_prescaler_a  (cfg_prescaler_a),
        .cfg_prescaler_b  (cfg_prescaler_b),
        .mem_rd_en        (mem_rd_en),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .timer_en         (timer_en),
        .timer_prescaler  (timer_prescaler),
        .timer_duration   (timer_duration),
        .timer_pulse      (timer_pulse),
        .tx_out           (tx_out),
        .busy             (busy),
        .done             (done)
    );

    // Symbol RAM: one-cycle read latency.
    logic [TW+1:0] sym_mem [32];
    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= sym_mem[mem_addr];
    end

    // Countdown timer: latches fields one cycle before each reload pulse,
    // pulses every ((dur+1) << psc) + 1 cycles.
    int tcnt;
    always @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tcnt <= 1;
            timer_pulse <= 1'b0;
        end else if (!timer_en) begin
            tcnt <= 1;
            timer_pulse <= 1'b0;
        end else if (tcnt == 1) begin
            tcnt <= ((int'(timer_duration) + 1) << timer_prescaler) + 1;
            timer_pulse <= 1'b1;
        end else begin
            tcnt <= tcnt - 1;
            timer_pulse <= 1'b0;
        end
    end

    typedef struct {
        bit is_done;
        bit level;
        int len;
    } exp_t;

    exp_t exp_q[$];
    int   addr_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   runs_en  = 1'b1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_unexpected(input string name, input int act);
        checks++;
        failures++;
        $display("FAIL %s: actual=%0d required=none", name, act);
    endtask

    task automatic push_run(input bit lvl, input int len);
        exp_t e;
        e.is_done = 1'b0;
        e.level   = lvl;
        e.len     = len;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.level   = 1'b0;
        e.len     = 0;
        exp_q.push_back(e);
    endtask

    function automatic logic [TW+1:0] mk_sym(input bit lvl, input bit psel, input int dur);
        return {lvl, psel, TW'(dur)};
    endfunction

    // Monitor: reads, completed symbol runs (closed by a tx edge or done) and done pulses.
    initial begin : monitor
        bit   prev_tx    = 1'b0;
        bit   run_active = 1'b0;
        int   run_len    = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!sys_rst_n) begin
                prev_tx    = tx_out;
                run_active = 1'b0;
                run_len    = 0;
            end else begin
                if (mem_rd_en) begin
                    if (addr_q.size() == 0) chk_unexpected("rd_addr_extra", int'(mem_addr));
                    else chk("rd_addr", int'(mem_addr), addr_q.pop_front());
                end
                if ((tx_out != prev_tx) || done) begin
                    if (run_active && runs_en) begin
                        if (exp_q.size() == 0 || exp_q[0].is_done) begin
                            chk_unexpected("run_extra", run_len);
                        end else begin
                            e = exp_q.pop_front();
                            chk("run_level", int'(prev_tx), int'(e.level));
                            chk("run_len", run_len, e.len);
                        end
                    end
                    run_active = busy;
                    run_len    = 1;
                    prev_tx    = tx_out;
                end else begin
                    run_len++;
                end
                if (!busy) run_active = 1'b0;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk_unexpected("done_extra", int'(done));
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_order", int'(done), int'(e.is_done));
                    end
                end
            end
        end
    end

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
        end
        chk("busy_cleared", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic load_prog1();
        sym_mem[0] = mk_sym(1'b1, 1'b0, 5);
        sym_mem[1] = mk_sym(1'b0, 1'b0, 3);
        sym_mem[2] = mk_sym(1'b1, 1'b1, 0);
        cfg_end_addr     = AW'(2);
        cfg_loop_count   = '0;
        cfg_loop_forever = 1'b0;
        cfg_invert       = 1'b0;
        cfg_idle_level   = 1'b0;
    endtask

    task automatic expect_prog1();
        push_run(1'b1, 7);
        push_run(1'b0, 5);
        push_run(1'b1, 7);
        push_done();
        addr_q.push_back(0);
        addr_q.push_back(1);
        addr_q.push_back(2);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        for (int i = 0; i < 32; i++) sym_mem[i] = '0;
        sys_rst_n       = 1'b0;
        start           = 1'b0;
        stop            = 1'b0;
        cfg_prescaler_a = PSC_W'(0);
        cfg_prescaler_b = PSC_W'(1);
        load_prog1();

        #12;
        chk("rst_tx_out", int'(tx_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_timer_en", int'(timer_en), 0);
        chk("rst_mem_rd_en", int'(mem_rd_en), 0);
        chk("rst_timer_duration", int'(timer_duration), 0);
        @(posedge clk);
        #1 sys_rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: three-symbol program, with a start request while busy
        expect_prog1();
        do_start();
        chk("t1_busy_after_start", int'(busy), 1);
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(200);
        chk("t1_tx_idle", int'(tx_out), 0);
        chk("t1_timer_off", int'(timer_en), 0);

        // 2: two symbols looped twice more, inverted output
        sym_mem[0]     = mk_sym(1'b0, 1'b0, 2);
        sym_mem[1]     = mk_sym(1'b1, 1'b1, 3);
        cfg_end_addr   = AW'(1);
        cfg_loop_count = LW'(2);
        cfg_invert     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_run(1'b1, 4);
            push_run(1'b0, 9);
            addr_q.push_back(0);
            addr_q.push_back(1);
        end
        push_done();
        do_start();
        wait_idle(300);
        chk("t2_tx_idle", int'(tx_out), 0);

        // 3: loop forever, stop 40 cycles after start
        cfg_invert       = 1'b0;
        cfg_loop_count   = '0;
        cfg_loop_forever = 1'b1;
        runs_en          = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr_q.push_back(0);
            addr_q.push_back(1);
        end
        push_done();
        do_start();
        repeat (39) @(posedge clk);
        #1;
        chk("t3_tx_before_stop", int'(tx_out), 1);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        chk("t3_timer_en", int'(timer_en), 0);
        chk("t3_tx_idle", int'(tx_out), 0);
        chk("t3_busy", int'(busy), 0);
        chk("t3_done", int'(done), 1);
        @(posedge clk);
        #1;
        chk("t3_done_one_cycle", int'(done), 0);
        runs_en = 1'b1;
        repeat (2) @(posedge clk);

        // 4: stop coincident with the first timer pulse
        load_prog1();
        addr_q.push_back(0);
        addr_q.push_back(1);
        push_done();
        do_start();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (timer_pulse) break;
        end
        chk("t4_pulse_seen", int'(timer_pulse), 1);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        chk("t4_tx_no_advance", int'(tx_out), 0);
        chk("t4_done", int'(done), 1);
        chk("t4_busy", int'(busy), 0);
        chk("t4_timer_en", int'(timer_en), 0);
        @(posedge clk);
        #1;
        chk("t4_idle_busy", int'(busy), 0);
        chk("t4_idle_done", int'(done), 0);
        chk("t4_idle_rd", int'(mem_rd_en), 0);

        // 5: reset while running, then a clean replay
        cfg_idle_level = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_idle_level", int'(tx_out), 1);
        addr_q.push_back(0);
        addr_q.push_back(1);
        do_start();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (timer_en) break;
        end
        chk("t5_timer_en_run", int'(timer_en), 1);
        #3 sys_rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", int'(tx_out), 0);
        chk("t5_rst_timer_en", int'(timer_en), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_done", int'(done), 0);
        chk("t5_rst_rd_en", int'(mem_rd_en), 0);
        chk("t5_rst_addr", int'(mem_addr), 0);
        chk("t5_rst_duration", int'(timer_duration), 0);
        cfg_idle_level = 1'b0;
        @(posedge clk);
        #1 sys_rst_n = 1'b1;
        repeat (2) @(posedge clk);
        expect_prog1();
        do_start();
        wait_idle(200);

        // 6: start together with stop while idle
        @(posedge clk);
        #1 begin
            start = 1'b1;
            stop  = 1'b1;
        end
        #1;
        chk("t6_no_rd", int'(mem_rd_en), 0);
        @(posedge clk);
        #1 begin
            start = 1'b0;
            stop  = 1'b0;
        end
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        repeat (5) @(posedge clk);
        #1;

        chk("sb_pending_events", exp_q.size(), 0);
        chk("sb_pending_reads", addr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
